led_fade_sequencer: RTL and testbench
=====================================

// Module: led_fade_sequencer
// PURPOSE
//   Owns the 8-bit duty levels of CHANNELS pwmGenerator instances and fades each one toward a commanded target.
//   Fades move one LSB per rate period, and the rate is set per channel.
//   A single shared step engine is triggered by a prescaler tick and scans the channels one per cycle.
//   Commands arrive over a valid/ready port from the board-level control logic (buttons, UART decoder).
// PARAMETERS
//   CHANNELS  4      number of PWM channels driven (>=1)
//   TICK_DIV  25000  clk cycles per fade tick (1 ms at 25 MHz); must be >= CHANNELS+2
//   CHW       $clog2(CHANNELS) (min 1)  channel index width, derived
// PORTS
//   clk         in   1           system clock, all logic on posedge
//   rst         in   1           asynchronous, active-high reset
//   cmd_valid   in   1           command present
//   cmd_ready   out  1           sequencer accepts command this cycle
//   cmd_chan    in   CHW         target channel; values >= CHANNELS are accepted and ignored
//   cmd_target  in   8           destination level
//   cmd_rate    in   8           ticks per LSB step; 0 = jump immediately
//   level_out   out  CHANNELS*8  duty level per channel, ch0 in [7:0]; wires to pwmGenerator level
//   busy        out  CHANNELS    channel level != target
//   done        out  CHANNELS    1-cycle pulse when a channel's busy falls
// BEHAVIOUR
// - Reset (async)
//   - All level, target, rate and rate-counter registers go to 0; state = IDLE; prescaler = 0.
//   - Outputs: level_out=0, busy=0, done=0, cmd_ready=0 while rst is high.
//   - Reset mid-fade abandons the fade; no done pulse is emitted.
// - Prescaler
//   - Free-running 0..TICK_DIV-1, including during SCAN.
//   - Wrap raises an internal tick for 1 cycle.
// - State machine
//   - IDLE: cmd_ready=1. tick -> SCAN with idx=0.
//   - SCAN: cmd_ready=0. Processes channel idx each cycle; idx==CHANNELS-1 -> IDLE.
//   - SCAN therefore lasts exactly CHANNELS cycles.
// - Command accept (cmd_valid & cmd_ready)
//   - On the next edge: target[ch] <= cmd_target, rate[ch] <= cmd_rate, ratecnt[ch] <= cmd_rate-1.
//   - If cmd_rate==0: level[ch] <= cmd_target on that same edge.
//   - Retargeting a fading channel keeps the current level and restarts its rate counter. Fading continues from the current level in the new direction.
// - Tick and accept in the same cycle: the command is applied, then SCAN starts next cycle and sees the new values.
// - SCAN step for channel c, when level != target:
//   - If ratecnt==0: level moves +/-1 toward target and ratecnt <= rate-1.
//   - Otherwise: ratecnt decrements.
//   - Channels with level==target are untouched.
// - Step arithmetic: never overshoots, never wraps (0 and 255 are terminal).
// - Fade duration: |target-level| * rate ticks.
// - busy and done
//   - busy is registered from (level != target).
//   - done[c] = busy_q & ~busy. This includes rate-0 jumps from a different level.
//   - A command whose target equals the current level produces no done pulse.
// - level_out latency: register value, 0 cycles after the level update edge (see CONFIGURATION).
// CONFIGURATION
//   LED_FADE_GAMMA_EN
//     defined: level_out = registered (L*(L+1))>>8 per channel, adding +1 cycle latency.
//       Mapping: 0->0, 128->64, 255->255.
//       busy/done timing is unchanged; busy/done may lead level_out by 1 cycle.
//     undefined: level_out = level registers directly (linear).
// TESTING  (CHANNELS=4, TICK_DIV=16)
// 1. Reset:
//    - Assert rst mid-cycle -> level_out=0, busy=0, cmd_ready=0 immediately.
//    - Release -> cmd_ready=1 in IDLE.
// 2. Linear fade:
//    - Command ch1 target=5 rate=1 -> level_out[15:8] steps 0,1..5, one step per tick (80 cycles total).
//    - busy[1] high throughout; single done[1] pulse; other channels stay 0.
// 3. Immediate jump:
//    - Command ch2 target=200 rate=0 -> level_out[23:16]=200 on the next edge.
//    - done[2] pulses 1 cycle later; no further change.
// 4. Retarget:
//    - Command ch0 target=10 rate=2; at level 4, command ch0 target=0 rate=1.
//    - Required: 4,3,2,1,0 at 1 step/tick; exactly one done[0].
// 5. Handshake:
//    - Hold cmd_valid across a tick -> cmd_ready low for exactly 4 cycles.
//    - Command accepted on the first IDLE cycle; no command lost or duplicated.
// 6. Boundaries:
//    - ch3 at 255, command target=255 -> no busy, no done.
//    - cmd_chan=5 -> ignored.
//    - With LED_FADE_GAMMA_EN: target 128 rate 0 -> level_out 64.

Source files
------------

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: owns the 8-bit duty levels of CHANNELS PWM generators and
// fades each one toward a commanded target at a per-channel rate.
//
// How it works:
//   - A free-running prescaler raises a one-cycle tick every TICK_DIV cycles.
//   - On each tick, a single shared step engine scans the channels, one per cycle.
//   - Commands are accepted only while the engine is idle.
//
// Handshake: a command transfers on a rising clk edge when cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the FSM state (and rst),
// never on cmd_valid. A producer may hold cmd_valid and its payload until the
// transfer edge.
//
// Optional build macro:
//   LED_FADE_GAMMA_EN -- level_out carries a registered (L*(L+1))>>8 gamma
//   curve instead of the linear level. This adds one cycle of latency.
module led_fade_sequencer #(
    parameter int CHANNELS = 4,
    parameter int TICK_DIV = 25000,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CHW-1:0]        cmd_chan,
    input  logic [7:0]            cmd_target,
    input  logic [7:0]            cmd_rate,
    output logic [CHANNELS*8-1:0] level_out,
    output logic [CHANNELS-1:0]   busy,
    output logic [CHANNELS-1:0]   done,
    output logic                  state_dbg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CHW-1:0] idx;
    logic          idx_last;
    logic [PW-1:0] presc;
    logic          tick;
    logic          accept;

    logic [7:0] level   [CHANNELS];
    logic [7:0] target  [CHANNELS];
    logic [7:0] rate    [CHANNELS];
    logic [7:0] ratecnt [CHANNELS];

    logic [CHANNELS-1:0] chan_hit;
    logic [CHANNELS-1:0] scan_hit;
    logic [CHANNELS-1:0] busy_nxt;
    logic [CHANNELS-1:0] busy_q;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign idx_last = (idx == CHW'(CHANNELS - 1));
    assign accept   = cmd_valid & cmd_ready;

    // Prescaler: free-running, keeps counting while the scan is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a tick starts a scan, and the last channel ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SCAN;
            SCAN:    if (idx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    // Commands are only taken while idle. This keeps them off the scan datapath.
    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        state_dbg = (state == SCAN);
    end

    // Scan index: walks 0..CHANNELS-1 during SCAN and rests at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (state == SCAN && !idx_last) begin
            idx <= idx + 1'b1;
        end else begin
            idx <= '0;
        end
    end

    // Per-channel decode.
    // Channel numbers >= CHANNELS match no channel, so they are dropped.
    // An accepted command sets busy from the new target; this lets a rate-0
    // jump still show busy for one cycle and produce a done pulse.
    always_comb begin
        chan_hit = '0;
        scan_hit = '0;
        busy_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_hit[c] = accept && (int'(cmd_chan) == c);
            scan_hit[c] = (state == SCAN) && (int'(idx) == c);
            busy_nxt[c] = chan_hit[c] ? (cmd_target != level[c])
                                      : (level[c] != target[c]);
        end
    end

    // Channel registers.
    // A command reloads the target, rate and rate counter.
    // The scan then steps the level one LSB toward the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                level[c]   <= '0;
                target[c]  <= '0;
                rate[c]    <= '0;
                ratecnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_hit[c]) begin
                    target[c]  <= cmd_target;
                    rate[c]    <= cmd_rate;
                    ratecnt[c] <= cmd_rate - 8'd1;
                    if (cmd_rate == 8'd0) begin
                        level[c] <= cmd_target;
                    end
                end else if (scan_hit[c] && (level[c] != target[c])) begin
                    if (ratecnt[c] == 8'd0) begin
                        level[c]   <= (level[c] < target[c]) ? level[c] + 8'd1
                                                             : level[c] - 8'd1;
                        ratecnt[c] <= rate[c] - 8'd1;
                    end else begin
                        ratecnt[c] <= ratecnt[c] - 8'd1;
                    end
                end
            end
        end
    end

    // Busy and its one-cycle-delayed copy.
    // done is the falling edge of busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= '0;
            busy_q <= '0;
        end else begin
            busy   <= busy_nxt;
            busy_q <= busy;
        end
    end

    assign done = busy_q & ~busy;

`ifdef LED_FADE_GAMMA_EN
    function automatic logic [7:0] gamma8(input logic [7:0] l);
        logic [15:0] p;
        p = 16'(l) * (16'(l) + 16'd1);
        return p[15:8];
    endfunction

    // Gamma output stage: registered square-law curve, one cycle behind level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_out <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                level_out[c*8 +: 8] <= gamma8(level[c]);
            end
        end
    end
`else
    // Linear output: level registers drive the PWM generators directly.
    always_comb begin
        level_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            level_out[c*8 +: 8] = level[c];
        end
    end
`endif

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer with CHANNELS=4 and TICK_DIV=16.
// Scoreboard entries are {channel, level_out value, step gap in cycles}.
// A gap of 0 means the gap is not compared.
module tb_led_fade_sequencer;

    localparam int CH  = 4;
    localparam int TD  = 16;
    localparam int W   = 26;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_chan = '0;
    logic [7:0]      cmd_target = '0;
    logic [7:0]      cmd_rate = '0;
    logic [CH*8-1:0] level_out;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
    logic            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt [CH];
    int last_cyc [CH];
    logic            mon_en = 1'b1;
    logic [CH*8-1:0] prev_lvl = '0;
    logic [W-1:0]    exp_q[$];

    led_fade_sequencer #(.CHANNELS(CH), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .level_out  (level_out),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ent(input int ch, input int v, input int gap);
        return {2'(ch), 8'(v), 16'(gap)};
    endfunction

    // Monitor: counts done pulses and pops an expected entry for every level change.
    always @(negedge clk) begin
        if (rst) begin
            prev_lvl = '0;
            for (int c = 0; c < CH; c++) last_cyc[c] = cyc;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (done[c]) done_cnt[c]++;
                if (mon_en && level_out[c*8 +: 8] != prev_lvl[c*8 +: 8]) begin
                    logic [W-1:0] e;
                    int gap;
                    gap = cyc - last_cyc[c];
                    last_cyc[c] = cyc;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_change", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_chan", c, e[25:24]);
                        check("sb_level", level_out[c*8 +: 8], e[23:16]);
                        if (e[15:0] != 16'd0) check("sb_gap", gap, e[15:0]);
                    end
                end
            end
            prev_lvl = level_out;
        end
    end

    // Driver: present a command and hold it until the transfer edge.
    // The task returns 1 time unit after that edge.
    task automatic send_cmd(input int ch, input int tgt, input int rt);
        int n;
        cmd_chan   = 2'(ch);
        cmd_target = 8'(tgt);
        cmd_rate   = 8'(rt);
        cmd_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) check("cmd_ready_wait", n, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_q_empty(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) check(tag, exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int lows, n, d;
        logic pr;
        for (int c = 0; c < CH; c++) begin
            done_cnt[c] = 0;
            last_cyc[c] = 0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", level_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_ready", cmd_ready, 1);
        idle(2);

`ifdef LED_FADE_GAMMA_EN
        // Gamma curve on rate-0 jumps: 128->64, 255->255, 0->0.
        send_cmd(2, 128, 0);
        exp_q.push_back(ent(2, 64, 0));
        @(posedge clk);
        #1;
        check("gamma_128", level_out[23:16], 64);
        idle(3);
        check("gamma_done_1", done_cnt[2], 1);
        send_cmd(2, 255, 0);
        exp_q.push_back(ent(2, 255, 0));
        @(posedge clk);
        #1;
        check("gamma_255", level_out[23:16], 255);
        send_cmd(2, 0, 0);
        exp_q.push_back(ent(2, 0, 0));
        @(posedge clk);
        #1;
        check("gamma_0", level_out[23:16], 0);
        idle(4);
        check("gamma_done_3", done_cnt[2], 3);
        check("gamma_q_empty", exp_q.size(), 0);
`else
        // Linear fade ch1 0->5 at rate 1: one step per tick.
        send_cmd(1, 5, 1);
        exp_q.push_back(ent(1, 1, 0));
        for (int v = 2; v <= 5; v++) exp_q.push_back(ent(1, v, TD));
        lows = 0;
        n = 0;
        while (level_out[15:8] != 8'd5 && n < 200) begin
            if (!busy[1]) lows++;
            @(posedge clk);
            #1;
            n++;
        end
        check("fade_reached", level_out[15:8], 5);
        check("fade_busy_low_cycles", lows, 0);
        idle(3);
        check("fade_done_cnt", done_cnt[1], 1);
        check("fade_busy_end", busy[1], 0);
        check("fade_other_ch", {level_out[31:16], level_out[7:0]}, 0);

        // Rate-0 jump on ch2: level on the next edge, done one cycle later.
        send_cmd(2, 200, 0);
        exp_q.push_back(ent(2, 200, 0));
        check("jump_level", level_out[23:16], 200);
        check("jump_done_early", done[2], 0);
        @(posedge clk);
        #1;
        check("jump_done_pulse", done[2], 1);
        @(posedge clk);
        #1;
        check("jump_done_end", done[2], 0);
        idle(40);
        check("jump_done_cnt", done_cnt[2], 1);
        check("jump_hold", level_out[23:16], 200);

        // Retarget ch0: up at rate 2 until level 4, then down to 0 at rate 1.
        send_cmd(0, 10, 2);
        exp_q.push_back(ent(0, 1, 0));
        for (int v = 2; v <= 4; v++) exp_q.push_back(ent(0, v, 2*TD));
        wait_q_empty("retarget_up_wait", 300);
        send_cmd(0, 0, 1);
        exp_q.push_back(ent(0, 3, 0));
        for (int v = 2; v >= 0; v--) exp_q.push_back(ent(0, v, TD));
        wait_q_empty("retarget_down_wait", 200);
        idle(3);
        check("retarget_level", level_out[7:0], 0);
        check("retarget_done_cnt", done_cnt[0], 1);

        // Handshake: hold a command across a tick, then count the not-ready cycles.
        n = 0;
        @(negedge clk);
        pr = cmd_ready;
        @(negedge clk);
        while (!(pr && !cmd_ready) && n < 60) begin
            pr = cmd_ready;
            n++;
            @(negedge clk);
        end
        check("hs_scan_seen", cmd_ready, 0);
        cmd_chan   = 2'd3;
        cmd_target = 8'd255;
        cmd_rate   = 8'd0;
        cmd_valid  = 1'b1;
        lows = 1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            lows++;
            n++;
            @(negedge clk);
        end
        check("hs_ready_low_cycles", lows, 4);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_q.push_back(ent(3, 255, 0));
        check("hs_first_idle_accept", level_out[31:24], 255);
        idle(40);
        check("hs_done_cnt", done_cnt[3], 1);

        // Boundaries: same target at 255 gives no busy and no done; 255 fades down cleanly.
        send_cmd(3, 255, 3);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy[3]) lows++;
            @(posedge clk);
            #1;
        end
        check("same_target_busy_cycles", lows, 0);
        check("same_target_done_cnt", done_cnt[3], 1);
        send_cmd(3, 253, 1);
        exp_q.push_back(ent(3, 254, 0));
        exp_q.push_back(ent(3, 253, TD));
        wait_q_empty("down_from_top_wait", 100);
        idle(3);
        check("down_from_top_done_cnt", done_cnt[3], 2);
        check("down_from_top_level", level_out[31:24], 253);
`endif

        // Reset mid-fade: outputs clear at once, and no done pulse follows.
        check("pre_rst_q_empty", exp_q.size(), 0);
        mon_en = 1'b0;
        send_cmd(1, 100, 1);
        idle(40);
        check("pre_rst_busy", busy[1], 1);
        d = done_cnt[1];
        #2;
        rst = 1'b1;
        #1;
        check("midrst_level", level_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release_ready", cmd_ready, 1);
        mon_en = 1'b1;
        idle(40);
        check("midrst_no_done", done_cnt[1], d);
        check("midrst_level_stays", level_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
